// File: rtl/spi_master_ctrl_if.sv
// Request/status and strobe bundle between a requester and the SPI sequencer.
// The sequencer takes the slave modport; the requester takes the master modport.
interface spi_master_ctrl_if;
  logic Start;
  logic Busy;
  logic Done;
  logic IsLoad;
  logic SftEn;
  logic SckWr;
  logic SckRd;
  logic Sck;
  logic CsN;

  modport master (
    output Start,
    input  Busy, Done, IsLoad, SftEn, SckWr, SckRd, Sck, CsN
  );

  modport slave (
    input  Start,
    output Busy, Done, IsLoad, SftEn, SckWr, SckRd, Sck, CsN
  );
endinterface

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 sequencer: chip select, divided SCK and per-edge strobes for a shift register.
// All outputs are registered and decoded from next state, so they line up with the state they describe.
module spi_master_ctrl #(
  parameter int SPI_LEN = 8,
  parameter int CLK_DIV = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  spi_master_ctrl_if.slave bus
);

  localparam int HW = $clog2(CLK_DIV) + 1;
  localparam int EW = $clog2(2 * SPI_LEN) + 1;
  localparam logic [HW-1:0] H_LAST = HW'(CLK_DIV - 1);
  localparam logic [EW-1:0] E_LAST = EW'(2 * SPI_LEN - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    LEAD = 3'd2,
    XFER = 3'd3,
    DONE = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [EW-1:0] ecnt_q, ecnt_d;

  logic busy_q, busy_d;
  logic done_q, done_d;
  logic load_q, load_d;
  logic sften_q, sften_d;
  logic sckwr_q, sckwr_d;
  logic sckrd_q, sckrd_d;
  logic sck_q, sck_d;
  logic csn_q, csn_d;

  // State and counter register
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      hcnt_q  <= '0;
      ecnt_q  <= '0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      ecnt_q  <= ecnt_d;
    end
  end

  // Next state: hcnt paces each half period, ecnt counts SCK edges within XFER
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    ecnt_d  = ecnt_q;
    case (state_q)
      IDLE: begin
        hcnt_d = '0;
        ecnt_d = '0;
        if (bus.Start) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        hcnt_d  = '0;
        state_d = LEAD;
      end
      LEAD: begin
        if (hcnt_q == H_LAST) begin
          hcnt_d  = '0;
          ecnt_d  = '0;
          state_d = XFER;
        end else begin
          hcnt_d = hcnt_q + HW'(1);
        end
      end
      XFER: begin
        if (hcnt_q == H_LAST) begin
          hcnt_d = '0;
          if (ecnt_q == E_LAST) begin
            ecnt_d  = '0;
            state_d = DONE;
          end else begin
            ecnt_d = ecnt_q + EW'(1);
          end
        end else begin
          hcnt_d = hcnt_q + HW'(1);
        end
      end
      DONE: begin
        hcnt_d  = '0;
        ecnt_d  = '0;
        state_d = IDLE;
      end
      default: begin
        hcnt_d  = '0;
        ecnt_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decoded from the next state; even edge index = SCK high phase
  always_comb begin
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
    load_d  = (state_d == LOAD);
    sften_d = 1'b0;
    sckwr_d = 1'b0;
    sckrd_d = 1'b0;
    sck_d   = 1'b0;
    csn_d   = 1'b1;
    case (state_d)
      LOAD, LEAD: begin
        csn_d = 1'b0;
      end
      XFER: begin
        csn_d   = 1'b0;
        sften_d = 1'b1;
        sck_d   = ~ecnt_d[0];
        sckrd_d = ~ecnt_d[0] && (hcnt_d == '0);
        // The last falling edge is CS hold only, nothing left to shift out
        sckwr_d = ecnt_d[0] && (hcnt_d == '0) && (ecnt_d != E_LAST);
      end
      default: begin
        csn_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      load_q  <= 1'b0;
      sften_q <= 1'b0;
      sckwr_q <= 1'b0;
      sckrd_q <= 1'b0;
      sck_q   <= 1'b0;
      csn_q   <= 1'b1;
    end else begin
      busy_q  <= busy_d;
      done_q  <= done_d;
      load_q  <= load_d;
      sften_q <= sften_d;
      sckwr_q <= sckwr_d;
      sckrd_q <= sckrd_d;
      sck_q   <= sck_d;
      csn_q   <= csn_d;
    end
  end

  assign bus.Busy   = busy_q;
  assign bus.Done   = done_q;
  assign bus.IsLoad = load_q;
  assign bus.SftEn  = sften_q;
  assign bus.SckWr  = sckwr_q;
  assign bus.SckRd  = sckrd_q;
  assign bus.Sck    = sck_q;
  assign bus.CsN    = csn_q;

  a_strobe_excl: assert property (@(posedge Clk) !(sckwr_q && sckrd_q));
  a_load_excl:   assert property (@(posedge Clk) !(load_q && sften_q));

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: D=4/LEN=8 instance plus a D=1/LEN=2 instance.
// Cycle 0 is the cycle in which Start is presented; outputs are sampled 1ns after each edge.
module tb_spi_master_ctrl;
  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

  spi_master_ctrl_if if0 ();
  spi_master_ctrl_if if1 ();

  spi_master_ctrl #(.SPI_LEN(8), .CLK_DIV(4)) dut0 (.Clk(Clk), .Rst(Rst), .bus(if0.slave));
  spi_master_ctrl #(.SPI_LEN(2), .CLK_DIV(1)) dut1 (.Clk(Clk), .Rst(Rst), .bus(if1.slave));

  int errors = 0;
  int checks = 0;

  logic r_csn [0:159];
  logic r_sck [0:159];
  logic r_rd  [0:159];
  logic r_wr  [0:159];
  logic r_ld  [0:159];
  logic r_sft [0:159];
  logic r_done[0:159];
  logic r_busy[0:159];
  logic [7:0] tx, sr, rx;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Drives Start/Rst per cycle, records outputs for cycles 1..n and runs a loopback shift-register model.
  task automatic observe(input int which, input int n, input int pa, input int pb,
                         input int hold_until, input int rst_at);
    bit s;
    sr = 8'h00;
    rx = 8'h00;
    s = (0 <= hold_until) || (pa == 0) || (pb == 0);
    if (which == 0) if0.Start = s; else if1.Start = s;
    for (int c = 1; c <= n; c++) begin
      tick();
      if (which == 0) begin
        r_csn[c] = if0.CsN;  r_sck[c] = if0.Sck;   r_rd[c] = if0.SckRd; r_wr[c] = if0.SckWr;
        r_ld[c]  = if0.IsLoad; r_sft[c] = if0.SftEn; r_done[c] = if0.Done; r_busy[c] = if0.Busy;
      end else begin
        r_csn[c] = if1.CsN;  r_sck[c] = if1.Sck;   r_rd[c] = if1.SckRd; r_wr[c] = if1.SckWr;
        r_ld[c]  = if1.IsLoad; r_sft[c] = if1.SftEn; r_done[c] = if1.Done; r_busy[c] = if1.Busy;
      end
      if (r_ld[c] === 1'b1) sr = tx;
      if (r_rd[c] === 1'b1) rx = {rx[6:0], sr[7]};
      if (r_wr[c] === 1'b1) sr = {sr[6:0], 1'b0};
      s = (c <= hold_until) || (c == pa) || (c == pb);
      if (which == 0) if0.Start = s; else if1.Start = s;
      Rst = (c == rst_at);
    end
    if0.Start = 1'b0;
    if1.Start = 1'b0;
    Rst = 1'b0;
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    if0.Start = 1'b0;
    if1.Start = 1'b0;
    repeat (3) tick();
    Rst = 1'b0;
    tick();
    checks++;
    if (if0.CsN !== 1'b1) begin errors++; $display("FAIL reset_csn: got %b expected 1", if0.CsN); end
    checks++;
    if (if0.Sck !== 1'b0) begin errors++; $display("FAIL reset_sck: got %b expected 0", if0.Sck); end
    checks++;
    if ({if0.IsLoad, if0.SftEn, if0.SckWr, if0.SckRd, if0.Done} !== 5'b0) begin
      errors++;
      $display("FAIL reset_strobes: got %b expected 00000",
               {if0.IsLoad, if0.SftEn, if0.SckWr, if0.SckRd, if0.Done});
    end
    checks++;
    if (if0.Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", if0.Busy); end
    checks++;
    if ({if1.CsN, if1.Sck, if1.Busy} !== 3'b100) begin
      errors++; $display("FAIL reset_dut1: got %b expected 100", {if1.CsN, if1.Sck, if1.Busy});
    end
  endtask

  task automatic test_single();
    int nrd, nwr, nld, ndone, first_rise, first_done, bad_csn, bad_sft, bad_excl;
    tx = 8'hA5;
    observe(0, 80, -1, -1, 0, -1);
    nrd = 0; nwr = 0; nld = 0; ndone = 0; first_rise = -1; first_done = -1;
    bad_csn = 0; bad_sft = 0; bad_excl = 0;
    for (int c = 1; c <= 80; c++) begin
      if (r_rd[c] === 1'b1) nrd++;
      if (r_wr[c] === 1'b1) nwr++;
      if (r_ld[c] === 1'b1) nld++;
      if (r_done[c] === 1'b1) begin ndone++; if (first_done < 0) first_done = c; end
      if (r_sck[c] === 1'b1 && first_rise < 0) first_rise = c;
      if (r_csn[c] !== ((c >= 1 && c <= 69) ? 1'b0 : 1'b1)) bad_csn++;
      if (r_sft[c] !== ((c >= 6 && c <= 69) ? 1'b1 : 1'b0)) bad_sft++;
      if ((r_rd[c] === 1'b1 && r_wr[c] === 1'b1) || (r_ld[c] === 1'b1 && r_sft[c] === 1'b1)) bad_excl++;
    end
    checks++;
    if (r_ld[1] !== 1'b1 || nld != 1) begin errors++; $display("FAIL single_load: ld[1]=%b count=%0d expected 1/1", r_ld[1], nld); end
    checks++;
    if (bad_csn != 0) begin errors++; $display("FAIL single_csn_window: bad cycles=%0d expected 0", bad_csn); end
    checks++;
    if (first_rise != 6) begin errors++; $display("FAIL single_first_rise: got %0d expected 6", first_rise); end
    checks++;
    if (nrd != 8) begin errors++; $display("FAIL single_sckrd_count: got %0d expected 8", nrd); end
    checks++;
    if (nwr != 7) begin errors++; $display("FAIL single_sckwr_count: got %0d expected 7", nwr); end
    checks++;
    if (first_done != 70 || ndone != 1) begin errors++; $display("FAIL single_done: at %0d count %0d expected 70/1", first_done, ndone); end
    checks++;
    if (r_busy[70] !== 1'b1 || r_busy[71] !== 1'b0) begin
      errors++; $display("FAIL single_busy_end: busy70=%b busy71=%b expected 1/0", r_busy[70], r_busy[71]);
    end
    checks++;
    if (bad_sft != 0) begin errors++; $display("FAIL single_sften_window: bad cycles=%0d expected 0", bad_sft); end
    checks++;
    if (bad_excl != 0) begin errors++; $display("FAIL single_exclusive: violations=%0d expected 0", bad_excl); end
    checks++;
    if (r_rd[6] !== 1'b1 || r_wr[10] !== 1'b1 || r_wr[66] !== 1'b0) begin
      errors++; $display("FAIL single_edge_pos: rd6=%b wr10=%b wr66=%b expected 1/1/0", r_rd[6], r_wr[10], r_wr[66]);
    end
  endtask

  task automatic test_loopback();
    tx = 8'hA5;
    observe(0, 75, -1, -1, 0, -1);
    checks++;
    if (rx !== 8'hA5) begin errors++; $display("FAIL loopback_a5: got %h expected a5", rx); end
    tx = 8'h3C;
    observe(0, 75, -1, -1, 0, -1);
    checks++;
    if (rx !== 8'h3C) begin errors++; $display("FAIL loopback_3c: got %h expected 3c", rx); end
  endtask

  task automatic test_ignore_start();
    int ndone, nld;
    tx = 8'h00;
    observe(0, 150, 30, 70, 0, -1);
    ndone = 0; nld = 0;
    for (int c = 1; c <= 150; c++) begin
      if (r_done[c] === 1'b1) ndone++;
      if (r_ld[c] === 1'b1) nld++;
    end
    checks++;
    if (ndone != 1 || nld != 1) begin errors++; $display("FAIL ignore_start: done=%0d load=%0d expected 1/1", ndone, nld); end
  endtask

  task automatic test_back_to_back();
    int ndone;
    observe(0, 150, -1, -1, 100, -1);
    ndone = 0;
    for (int c = 1; c <= 150; c++) if (r_done[c] === 1'b1) ndone++;
    checks++;
    if (r_done[70] !== 1'b1 || r_busy[71] !== 1'b0 || r_ld[72] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_gap: done70=%b busy71=%b ld72=%b expected 1/0/1", r_done[70], r_busy[71], r_ld[72]);
    end
    checks++;
    if (r_done[141] !== 1'b1 || ndone != 2) begin
      errors++; $display("FAIL b2b_second: done141=%b count=%0d expected 1/2", r_done[141], ndone);
    end
  endtask

  task automatic test_reset_mid();
    int ndone;
    tx = 8'hFF;
    observe(0, 110, -1, -1, 0, 31);
    ndone = 0;
    for (int c = 1; c <= 110; c++) if (r_done[c] === 1'b1) ndone++;
    checks++;
    if (r_sck[31] !== 1'b1) begin errors++; $display("FAIL rstmid_phase: sck31=%b expected 1", r_sck[31]); end
    checks++;
    if ({r_csn[32], r_sck[32], r_sft[32], r_busy[32]} !== 4'b1000) begin
      errors++;
      $display("FAIL rstmid_abort: csn/sck/sft/busy=%b%b%b%b expected 1000", r_csn[32], r_sck[32], r_sft[32], r_busy[32]);
    end
    checks++;
    if (ndone != 0) begin errors++; $display("FAIL rstmid_nodone: got %0d expected 0", ndone); end
    tx = 8'h5A;
    observe(0, 75, -1, -1, 0, -1);
    checks++;
    if (r_done[70] !== 1'b1 || rx !== 8'h5A) begin
      errors++; $display("FAIL rstmid_recover: done70=%b rx=%h expected 1/5a", r_done[70], rx);
    end
  endtask

  task automatic test_d1();
    int first_done;
    logic [7:0] strb;
    logic [5:0] sckp;
    observe(1, 12, -1, -1, 0, -1);
    first_done = -1;
    for (int c = 1; c <= 12; c++) if (r_done[c] === 1'b1 && first_done < 0) first_done = c;
    strb = {r_rd[3], r_wr[3], r_rd[4], r_wr[4], r_rd[5], r_wr[5], r_rd[6], r_wr[6]};
    sckp = {r_sck[2], r_sck[3], r_sck[4], r_sck[5], r_sck[6], r_sck[7]};
    checks++;
    if (first_done != 7) begin errors++; $display("FAIL d1_done: got %0d expected 7", first_done); end
    checks++;
    if (strb !== 8'b10011000) begin errors++; $display("FAIL d1_strobes: got %b expected 10011000", strb); end
    checks++;
    if (sckp !== 6'b010100) begin errors++; $display("FAIL d1_sck: got %b expected 010100", sckp); end
    checks++;
    if (r_ld[1] !== 1'b1 || r_busy[8] !== 1'b0) begin
      errors++; $display("FAIL d1_frame: ld1=%b busy8=%b expected 1/0", r_ld[1], r_busy[8]);
    end
  endtask

  initial begin
    Rst = 1'b1;
    if0.Start = 1'b0;
    if1.Start = 1'b0;
    tx = 8'h00;
    test_reset();
    test_single();
    test_loopback();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_d1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
